// File: rtl/event_fetch_requester.sv
// Event fetch requester: issues one-cycle requests to an event source, buffers
// the responses in a small first-word-fall-through FIFO and streams them out.
// Each request is guarded by a timeout. Done and sticky error flags report status.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; FIFO may still be draining
// S_REQ   | request is on the wire this cycle, or held off by a full FIFO
// S_WAIT  | waiting for the response strobe, timeout counting down
// S_DRAIN | run finished or aborted; waiting for the FIFO to empty
module event_fetch_requester #(
    parameter int DATA_WIDTH     = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  event_total,
    output logic                  out_event_req_0,
    input  logic                  in_event_valid_0,
    input  logic [DATA_WIDTH-1:0] in_event_value_0,
    input  logic [15:0]           in_event_addr_0,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_value,
    output logic [7:0]            m_row,
    output logic [7:0]            m_col,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  fetched_cnt,
    output logic                  timeout_err,
    output logic                  stray_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ENT_W = DATA_WIDTH + 16;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_C   = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic [CNT_WIDTH-1:0]  fetched_q, fetched_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tmo_err_q, tmo_err_d;
    logic                  stray_q, stray_d;

    logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  push, pop;
    logic [ENT_W-1:0]      head;

    // Sequencer next-state; the timeout counter loads the full window on entry
    // to WAIT and aborts on the last tolerated silent cycle.
    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        fetched_d = fetched_q;
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
        stray_d   = stray_q;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d   = event_total;
                    fetched_d = '0;
                    tmo_err_d = 1'b0;
                    stray_d   = 1'b0;
                    state_d   = (event_total == '0) ? S_DRAIN : S_REQ;
                end
                if (in_event_valid_0) stray_d = 1'b1;
            end
            S_REQ: begin
                if (req_q) begin
                    tmo_d   = TMO_C;
                    state_d = S_WAIT;
                end
                if (in_event_valid_0) stray_d = 1'b1;
            end
            S_WAIT: begin
                if (in_event_valid_0) begin
                    push      = 1'b1;
                    fetched_d = (fetched_q == total_q) ? fetched_q : fetched_q + 1'b1;
                    state_d   = (fetched_d == total_q) ? S_DRAIN : S_REQ;
                end else if (tmo_q <= TMO_W'(1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = S_DRAIN;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (occ_q == '0) state_d = S_IDLE;
                if (in_event_valid_0) stray_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointer and occupancy update; a simultaneous push and pop cancel out.
    always_comb begin
        pop      = (occ_q != '0) && m_ready;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        occ_d    = occ_q;
        if (push && !pop) occ_d = occ_q + 1'b1;
        if (pop && !push) occ_d = occ_q - 1'b1;
    end

    // Registered outputs; req is decided one edge early from next-cycle occupancy
    // so the request lands in the first REQ cycle with no extra latency.
    always_comb begin
        req_d  = (state_d == S_REQ) && (occ_d < DEPTH_C);
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DRAIN) && (occ_q == '0);
    end

    // State and control flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            total_q   <= '0;
            fetched_q <= '0;
            tmo_q     <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            stray_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            fetched_q <= fetched_d;
            tmo_q     <= tmo_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_err_q <= tmo_err_d;
            stray_q   <= stray_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
        end
    end

    // FIFO storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_event_value_0, in_event_addr_0};
    end

`ifndef SYNTHESIS
    // A push into a full FIFO means the occupancy gate in REQ was bypassed.
    always @(posedge clk) begin
        if (!rst) assert (!(push && occ_q == DEPTH_C));
    end
`endif

    assign head            = mem_q[rd_ptr_q];
    assign m_valid         = (occ_q != '0);
    assign m_value         = head[ENT_W-1:16];
    assign m_row           = head[15:8];
    assign m_col           = head[7:0];
    assign out_event_req_0 = req_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign fetched_cnt     = fetched_q;
    assign timeout_err     = tmo_err_q;
    assign stray_err       = stray_q;
endmodule

// File: tb/tb_event_fetch_requester.sv
// Bench for event_fetch_requester: a one-cycle-latency source model feeds a
// scoreboard of expected events, which the output monitor pops and compares.
module tb_event_fetch_requester;
    localparam int DW   = 4;
    localparam int DEP  = 4;
    localparam int TMO  = 16;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] event_total;
    logic          out_event_req_0;
    logic          in_event_valid_0;
    logic [DW-1:0] in_event_value_0;
    logic [15:0]   in_event_addr_0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_value;
    logic [7:0]    m_row;
    logic [7:0]    m_col;
    logic          busy;
    logic          done;
    logic [CW-1:0] fetched_cnt;
    logic          timeout_err;
    logic          stray_err;

    event_fetch_requester #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .event_total(event_total),
        .out_event_req_0(out_event_req_0), .in_event_valid_0(in_event_valid_0),
        .in_event_value_0(in_event_value_0), .in_event_addr_0(in_event_addr_0),
        .m_valid(m_valid), .m_ready(m_ready), .m_value(m_value), .m_row(m_row),
        .m_col(m_col), .busy(busy), .done(done), .fetched_cnt(fetched_cnt),
        .timeout_err(timeout_err), .stray_err(stray_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // scoreboard and monitor state
    logic [19:0] sb[$];
    int          req_cyc[$];
    int          req_cnt, done_cnt, pops, first_mv, tmo_cyc;
    bit          tmo_seen;
    int          src_budget = 0;
    int          src_idx = 0;
    bit          stray_req = 1'b0;
    bit          req_seen = 1'b0;

    // Source model: answers a request one cycle later while its budget lasts.
    initial begin
        in_event_valid_0 = 1'b0;
        in_event_value_0 = '0;
        in_event_addr_0  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_event_valid_0 = 1'b0;
                req_seen = 1'b0;
            end else begin
                if (req_seen && src_budget > 0) begin
                    in_event_valid_0 = 1'b1;
                    in_event_value_0 = DW'(src_idx + 1);
                    in_event_addr_0  = {8'(2 * src_idx + 1), 8'(2 * src_idx + 2)};
                    sb.push_back({in_event_value_0, in_event_addr_0});
                    src_idx++;
                    src_budget--;
                end else if (stray_req) begin
                    in_event_valid_0 = 1'b1;
                    in_event_value_0 = 4'hF;
                    in_event_addr_0  = 16'hABCD;
                    stray_req = 1'b0;
                end else begin
                    in_event_valid_0 = 1'b0;
                end
                req_seen = out_event_req_0;
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_event_req_0) begin
                req_cnt++;
                req_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
            if (timeout_err && !tmo_seen) begin
                tmo_seen = 1'b1;
                tmo_cyc  = cyc;
            end
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (m_valid && m_ready) begin
                pops++;
                if (sb.size() == 0) check_val("pop_unexpected", 32'(m_valid & m_ready), 32'd0);
                else check_val("m_data", 32'({m_value, m_row, m_col}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_run();
        req_cnt = 0; done_cnt = 0; pops = 0; first_mv = -1;
        tmo_seen = 1'b0; tmo_cyc = 0; src_idx = 0;
        req_cyc.delete();
    endtask

    task automatic do_start(input logic [CW-1:0] tot, output int c0);
        start = 1'b1;
        event_total = tot;
        c0 = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, at;
        bit ok;
        rst = 1'b1; start = 1'b0; event_total = '0; m_ready = 1'b0;
        clr_run();
        tick(2);
        check_val("rst_outs", 32'({out_event_req_0, m_valid, busy, done, timeout_err, stray_err}), 32'd0);
        check_val("rst_fetched", 32'(fetched_cnt), 32'd0);
        rst = 1'b0;
        tick(2);

        // basic run: 3 events, free-flowing output
        clr_run();
        m_ready = 1'b1; src_budget = 3;
        do_start(16'd3, c0);
        wait_done(40, ok, at);
        check_val("basic_done_seen", 32'(ok), 32'd1);
        check_val("basic_done_cyc", 32'(at - c0), 32'd9);
        tick(2);
        check_val("basic_req_cnt", 32'(req_cnt), 32'd3);
        check_val("basic_req0", 32'(req_cyc[0] - c0), 32'd1);
        check_val("basic_req1", 32'(req_cyc[1] - c0), 32'd3);
        check_val("basic_req2", 32'(req_cyc[2] - c0), 32'd5);
        check_val("basic_mvalid_lat", 32'(first_mv - c0), 32'd3);
        check_val("basic_pops", 32'(pops), 32'd3);
        check_val("basic_done_cnt", 32'(done_cnt), 32'd1);
        check_val("basic_fetched", 32'(fetched_cnt), 32'd3);
        check_val("basic_flags", 32'({busy, timeout_err, stray_err}), 32'd0);

        // backpressure: FIFO of 4 fills, requests stop until the sink accepts
        clr_run();
        m_ready = 1'b0; src_budget = 100;
        do_start(16'd10, c0);
        tick(30);
        check_val("bp_req_cnt_full", 32'(req_cnt), 32'd4);
        check_val("bp_fetched_full", 32'(fetched_cnt), 32'd4);
        check_val("bp_busy_valid", 32'({busy, m_valid, out_event_req_0}), 32'b110);
        tick(10);
        check_val("bp_req_hold", 32'(req_cnt), 32'd4);
        m_ready = 1'b1;
        wait_done(200, ok, at);
        check_val("bp_done_seen", 32'(ok), 32'd1);
        check_val("bp_empty_at_done", 32'(m_valid), 32'd0);
        tick(2);
        check_val("bp_pops", 32'(pops), 32'd10);
        check_val("bp_req_total", 32'(req_cnt), 32'd10);
        check_val("bp_fetched", 32'(fetched_cnt), 32'd10);
        check_val("bp_done_cnt", 32'(done_cnt), 32'd1);
        check_val("bp_sb_left", 32'(sb.size()), 32'd0);

        // timeout: source goes silent after two events
        clr_run();
        m_ready = 1'b0; src_budget = 2;
        do_start(16'd5, c0);
        for (int i = 0; i < 60 && !tmo_seen; i++) tick(1);
        check_val("tmo_seen", 32'(tmo_seen), 32'd1);
        check_val("tmo_latency", 32'(tmo_cyc - req_cyc[2]), 32'(TMO + 1));
        check_val("tmo_drain_hold", 32'({busy, m_valid, done}), 32'b110);
        tick(5);
        check_val("tmo_no_4th_req", 32'(req_cnt), 32'd3);
        m_ready = 1'b1;
        wait_done(20, ok, at);
        check_val("tmo_done_seen", 32'(ok), 32'd1);
        tick(2);
        check_val("tmo_pops", 32'(pops), 32'd2);
        check_val("tmo_fetched", 32'(fetched_cnt), 32'd2);
        check_val("tmo_flags", 32'({busy, timeout_err, stray_err}), 32'b010);

        // stray valid in IDLE, then a zero-length run
        clr_run();
        stray_req = 1'b1;
        tick(3);
        check_val("stray_set", 32'(stray_err), 32'd1);
        check_val("stray_fifo_empty", 32'(m_valid), 32'd0);
        check_val("stray_fetched_kept", 32'(fetched_cnt), 32'd2);
        do_start(16'd0, c0);
        check_val("zero_clears", 32'({busy, stray_err, timeout_err}), 32'b100);
        wait_done(10, ok, at);
        check_val("zero_done_cyc", 32'(at - c0), 32'd2);
        tick(2);
        check_val("zero_idle", 32'({busy, req_cnt[0], m_valid}), 32'd0);
        check_val("zero_done_cnt", 32'(done_cnt), 32'd1);

        // start while busy is ignored
        clr_run();
        m_ready = 1'b1; src_budget = 100;
        do_start(16'd4, c0);
        tick(3);
        do_start(16'd1, at);
        wait_done(40, ok, at);
        check_val("ign_done_seen", 32'(ok), 32'd1);
        tick(2);
        check_val("ign_fetched", 32'(fetched_cnt), 32'd4);
        check_val("ign_pops", 32'(pops), 32'd4);
        check_val("ign_done_cnt", 32'(done_cnt), 32'd1);

        // reset in WAIT with two events buffered
        clr_run();
        m_ready = 1'b0; src_budget = 2;
        do_start(16'd6, c0);
        for (int i = 0; i < 40 && req_cnt < 3; i++) tick(1);
        check_val("rst_pre_req3", 32'(req_cnt), 32'd3);
        tick(2);
        check_val("rst_pre_state", 32'({busy, m_valid, 14'(fetched_cnt)}), 32'({1'b1, 1'b1, 14'd2}));
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_mid_outs", 32'({out_event_req_0, m_valid, busy, done, timeout_err, stray_err}), 32'd0);
        check_val("rst_mid_fetched", 32'(fetched_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        tick(3);
        check_val("post_rst_idle", 32'({out_event_req_0, m_valid, busy, done}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
